// File: rtl/mux_rr_reg.sv
//==============================================================================
// Module   : mux_rr_reg
// Brief    : N-channel registered valid/ready mux, fixed-select or round-robin.
//            Optional even-parity output enabled by `define MUX_RR_PARITY_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mux_rr_reg #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH*WIDTH-1:0]  in_data,
   input  logic [NCH-1:0]        in_valid,
   output logic [NCH-1:0]        in_ready,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SELW-1:0]       out_ch
`ifdef MUX_RR_PARITY_EN
   ,
   output logic                  out_par
`endif
);

   localparam int NSLOT = 1 << SELW;

   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  grant;
   logic             grant_vld;
   logic             load_en;
   logic [SELW:0]    cand;
   logic [NSLOT-1:0] valid_pad;
   logic [WIDTH-1:0] ch_data [NSLOT];
   logic [WIDTH-1:0] sel_data;

   // Pad channels up to the full index space so out-of-range indices read as idle.
   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      if (i < NCH) begin : g_live
         assign ch_data[i]   = in_data[i*WIDTH +: WIDTH];
         assign valid_pad[i] = in_valid[i];
      end else begin : g_pad
         assign ch_data[i]   = '0;
         assign valid_pad[i] = 1'b0;
      end
   end

   assign load_en  = !out_valid || out_ready;
   assign sel_data = ch_data[grant];

   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      if (!mode) begin
         if (valid_pad[sel]) begin
            grant_vld = 1'b1;
            grant     = sel;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_ptr} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(NCH)) begin
               cand = cand - (SELW+1)'(NCH);
            end
            if (!grant_vld && valid_pad[cand[SELW-1:0]]) begin
               grant_vld = 1'b1;
               grant     = cand[SELW-1:0];
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && grant_vld) begin
         in_ready = NCH'(1) << grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         out_valid <= grant_vld;
         if (grant_vld) begin
            out_data <= sel_data;
            out_ch   <= grant;
            if (mode) begin
               rr_ptr <= (grant == SELW'(NCH-1)) ? '0 : grant + SELW'(1);
            end
         end
      end
   end

`ifdef MUX_RR_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par <= 1'b0;
      end else if (load_en && grant_vld) begin
         out_par <= ^sel_data;
      end
   end
`endif

endmodule

`default_nettype wire
